// File: rtl/spw_txbuf.sv
// SpaceWire transmit buffer: first-word-fall-through FIFO between the host
// write port and the transmitter, with fill-level flags and sticky
// overflow/underflow error flags.
module spw_txbuf #(
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 4,
    parameter int unsigned AFULL_LVL = 12
) (
    input  logic          CLK_i,
    input  logic          RST_i,
    input  logic          wr_txbuf_i,
    input  logic [DW-1:0] txbuf_data_i,
    output logic          txbuf_full_o,
    output logic          txbuf_afull_o,
    output logic [DW-1:0] tx_data_o,
    output logic          tx_valid_o,
    input  logic          tx_rd_i,
    output logic [AW:0]   txbuf_count_o,
    output logic          ovf_err_o,
    output logic          udf_err_o,
    input  logic          clr_err_i
);

    localparam int unsigned DEPTH = 32'd1 << AW;
    localparam int unsigned CW    = AW + 1;

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_ovf;
    logic          r_udf;

    logic          w_full;
    logic          w_valid;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_ovf_set;
    logic          w_udf_set;

    // Reset synchronizer: assertion passes straight through, release is
    // delayed two clock edges so the FIFO leaves reset cleanly.
    always_ff @(posedge CLK_i or negedge RST_i) begin
        if (!RST_i) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Status decodes from the registered count only.
    always_comb begin
        w_full    = (r_count == CW'(DEPTH));
        w_valid   = (r_count != '0);
        w_wr_acc  = wr_txbuf_i && !w_full;
        w_rd_acc  = tx_rd_i && w_valid;
        w_ovf_set = wr_txbuf_i && w_full;
        w_udf_set = tx_rd_i && !w_valid;
    end

    // Fill-level update: +1 write-only, -1 pop-only, else hold.
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array: no reset, contents only visible while count > 0.
    always_ff @(posedge CLK_i) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= txbuf_data_i;
        end
    end

    // Pointers, fill count and sticky error flags; a new error beats a clear.
    always_ff @(posedge CLK_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_set || (r_ovf && !clr_err_i);
            r_udf   <= w_udf_set || (r_udf && !clr_err_i);
        end
    end

    // Output drive; head data is forced to zero when nothing is queued.
    always_comb begin
        txbuf_full_o  = w_full;
        txbuf_afull_o = (r_count >= CW'(AFULL_LVL));
        tx_valid_o    = w_valid;
        tx_data_o     = w_valid ? r_mem[r_rd_ptr] : '0;
        txbuf_count_o = r_count;
        ovf_err_o     = r_ovf;
        udf_err_o     = r_udf;
    end

endmodule

// File: doc/spw_txbuf.md
SPW_TXBUF -- requirements
Module: spw_txbuf

Interface
REQ-001 Parameter DW, default 8: data width of one buffered byte/N-Char, matching the host-side buffer width.
REQ-002 Parameter AW, default 4: address width; depth = 2^AW entries (16).
REQ-003 Parameter AFULL_LVL, default 12: fill level at and above which almost-full asserts; legal range 1..2^AW.
REQ-004 CLK_i  in  1  single clock; all state changes on its rising edge.
REQ-005 RST_i  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous release.
REQ-006 wr_txbuf_i  in  1  write strobe from the host/communication-memory interface.
REQ-007 txbuf_data_i  in  DW  write data, sampled when wr_txbuf_i=1.
REQ-008 txbuf_full_o  out  1  buffer holds 2^AW entries.
REQ-009 txbuf_afull_o  out  1  count >= AFULL_LVL.
REQ-010 tx_data_o  out  DW  head-of-queue data to the transmitter, first-word-fall-through.
REQ-011 tx_valid_o  out  1  tx_data_o holds a valid entry (count > 0).
REQ-012 tx_rd_i  in  1  transmitter pop; consumes head entry when tx_valid_o=1.
REQ-013 txbuf_count_o  out  AW+1  current fill level, 0..2^AW.
REQ-014 ovf_err_o  out  1  sticky: write attempted while full.
REQ-015 udf_err_o  out  1  sticky: pop attempted while empty.
REQ-016 clr_err_i  in  1  synchronous clear of both sticky error flags.

Function
REQ-017 Storage SHALL be a 2^AW x DW array with no reset, written synchronously and read asynchronously at the read pointer.
REQ-018 Write accepted iff wr_txbuf_i=1 and txbuf_full_o=0 at the edge; data stored at wr_ptr, wr_ptr increments modulo 2^AW.
REQ-019 Pop accepted iff tx_rd_i=1 and tx_valid_o=0 is false (tx_valid_o=1) at the edge; rd_ptr increments modulo 2^AW.
REQ-020 Count SHALL be +1 on write-only, -1 on pop-only, unchanged on simultaneous accepted write and pop or on neither.
REQ-021 Full/empty SHALL be decided from the registered count before the edge; a pop in the same cycle does not admit a write when full.
REQ-022 Write to empty buffer SHALL make tx_valid_o=1 and tx_data_o=written data in the cycle after the accepting edge (latency 1).
REQ-023 tx_data_o SHALL be 0 whenever tx_valid_o=0; otherwise mem[rd_ptr].
REQ-024 txbuf_full_o, txbuf_afull_o, tx_valid_o SHALL be combinational decodes of the registered count only.
REQ-025 Write while full: data discarded, pointers/count unchanged, ovf_err_o set at that edge.
REQ-026 Pop while empty: ignored, pointers/count unchanged, udf_err_o set at that edge; a simultaneous write into empty is still accepted.
REQ-027 clr_err_i=1 clears both error flags at the edge; a new error in the same cycle SHALL win (flag stays 1).
REQ-028 Pointers SHALL wrap from 2^AW-1 to 0 with no gap; data order strictly FIFO across wrap.

Reset
REQ-029 RST_i=0 SHALL immediately force wr_ptr=0, rd_ptr=0, count=0, ovf_err_o=0, udf_err_o=0.
REQ-030 During and after reset: txbuf_full_o=0, txbuf_afull_o=0, tx_valid_o=0, tx_data_o=0, txbuf_count_o=0.
REQ-031 Reset mid-operation SHALL discard all stored entries; array contents are don't-care and never visible since tx_valid_o=0.

Verification
REQ-032 Reset, write 0xA5 once -> next cycle tx_valid_o=1, tx_data_o=0xA5, count=1; pop -> next cycle tx_valid_o=0, tx_data_o=0x00, count=0.
REQ-033 Write 0x00..0x0F without pops -> afull at count=12, full at count=16; 17th write 0x10 -> ovf_err_o=1, count stays 16; pops return 0x00..0x0F in order.
REQ-034 Fill to 8, then 40 cycles of simultaneous write/pop with incrementing data -> count constant 8, output sequence contiguous across pointer wrap.
REQ-035 Empty buffer, tx_rd_i=1 with wr_txbuf_i=1 data 0x3C -> udf_err_o=1, count=1, tx_data_o=0x3C next cycle.
REQ-036 ovf_err_o=1, assert clr_err_i with no error -> flag 0 next cycle; assert clr_err_i together with a full-write -> flag remains 1.
REQ-037 Fill to 10, assert RST_i=0 asynchronously mid-cycle -> all outputs 0 before next edge; after release first write 0x55 appears as sole entry.
